// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared encodings for the MEM-stage access sequencer
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    MAC_IDLE   = 2'd0,
    MAC_ACCESS = 2'd1,
    MAC_DONE   = 2'd2,
    MAC_DRAIN  = 2'd3
  } mac_state_e;

  // mem_op decode: 1XXX is a load, 01XX is a store, anything else is no access
  localparam logic [3:0] OP_LOAD_MASK   = 4'b1000;
  localparam logic [3:0] OP_LOAD_MATCH  = 4'b1000;
  localparam logic [3:0] OP_STORE_MASK  = 4'b1100;
  localparam logic [3:0] OP_STORE_MATCH = 4'b0100;

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

  localparam int TMO_W = 8;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op & OP_LOAD_MASK) == OP_LOAD_MATCH;
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op & OP_STORE_MASK) == OP_STORE_MATCH;
  endfunction

endpackage

// File: rtl/mac_timeout_cnt.sv
// rtl/mac_timeout_cnt.sv - saturating bus-wait counter with terminal-count flag
module mac_timeout_cnt #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  // at_limit marks the last allowed wait cycle, so the caller times out
  // after exactly LIMIT cycles without an ack.
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] SAT  = {W{1'b1}};

  logic [W-1:0] count;

  // Count wait cycles; clear starts a fresh window, hold at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != SAT)) begin
      count <= count + W'(1);
    end
  end

  assign at_limit = (count >= LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store to bus req/ack sequencer with stall hold
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_stall,
  input  logic              mem_flush,
  output logic              mem_busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              mem_err,
  output logic              bus_req,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  output logic [1:0]        bus_size,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_err
);

  mac_state_e state_q;
  mac_state_e state_d;

  logic access;
  logic start_acc;
  logic complete;
  logic clear_resp;
  logic tmo_en;
  logic tmo_at_limit;
  logic timeout;

  assign access  = op_is_load(mem_op) || op_is_store(mem_op);
  assign timeout = tmo_at_limit && !bus_ack;

  // Counter restarts on each new access and keeps running through a drain,
  // so a flushed transaction cannot hold the bus longer than one window.
  mac_timeout_cnt #(
    .W     (TMO_W),
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_acc),
    .en       (tmo_en),
    .at_limit (tmo_at_limit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MAC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, handshake outputs and datapath strobes
  always_comb begin
    state_d    = state_q;
    mem_busy   = 1'b0;
    bus_req    = 1'b0;
    rd_valid   = 1'b0;
    start_acc  = 1'b0;
    complete   = 1'b0;
    clear_resp = 1'b0;
    tmo_en     = 1'b0;
    case (state_q)
      MAC_IDLE: begin
        if (access && !mem_flush) begin
          mem_busy  = 1'b1;
          start_acc = 1'b1;
          state_d   = MAC_ACCESS;
        end
      end
      MAC_ACCESS: begin
        mem_busy = 1'b1;
        bus_req  = 1'b1;
        tmo_en   = !bus_ack;
        if (mem_flush) begin
          // A transaction that ends in the flush cycle has nothing left to drain
          state_d = (bus_ack || timeout) ? MAC_IDLE : MAC_DRAIN;
        end else if (bus_ack || timeout) begin
          complete = 1'b1;
          state_d  = MAC_DONE;
        end
      end
      MAC_DRAIN: begin
        mem_busy = 1'b1;
        bus_req  = 1'b1;
        tmo_en   = !bus_ack;
        if (bus_ack || timeout) begin
          state_d = MAC_IDLE;
        end
      end
      MAC_DONE: begin
        rd_valid = 1'b1;
        // Stall holds the result; the op is never re-issued from here
        if (mem_flush || !mem_stall) begin
          clear_resp = 1'b1;
          state_d    = MAC_IDLE;
        end
      end
      default: begin
        state_d = MAC_IDLE;
      end
    endcase
  end

  // Bus request fields are captured once per op and held for the whole transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rw      <= BUS_READ;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      bus_size    <= 2'b00;
    end else if (start_acc) begin
      bus_rw      <= op_is_store(mem_op) ? BUS_WRITE : BUS_READ;
      bus_addr    <= mem_addr;
      bus_wr_data <= mem_wr_data;
      bus_size    <= mem_op[1:0];
    end
  end

  // Completion result: load data on ack, error on bus_err or timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      mem_err <= 1'b0;
    end else if (complete) begin
      rd_data <= (bus_ack && (bus_rw == BUS_READ)) ? bus_rd_data : '0;
      mem_err <= bus_ack ? bus_err : 1'b1;
    end else if (clear_resp) begin
      rd_data <= '0;
      mem_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_stall;
  logic        mem_flush;
  logic        mem_busy;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        mem_err;
  logic        bus_req;
  logic        bus_rw;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [1:0]  bus_size;
  logic        bus_ack;
  logic [31:0] bus_rd_data;
  logic        bus_err;

  logic [3:0]  t_op;
  logic [31:0] t_addr;
  logic        t_busy;
  logic [31:0] t_rd_data;
  logic        t_valid;
  logic        t_err;
  logic        t_req;
  logic        t_rw;
  logic [31:0] t_bus_addr;
  logic [31:0] t_bus_wr_data;
  logic [1:0]  t_size;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   req_rises = 0;
  int   rises_before;
  logic valid_prev = 1'b0;
  logic req_prev   = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) u_dut (
    .clk(clk), .rst(rst), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_stall(mem_stall), .mem_flush(mem_flush),
    .mem_busy(mem_busy), .rd_data(rd_data), .rd_valid(rd_valid), .mem_err(mem_err),
    .bus_req(bus_req), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_size(bus_size), .bus_ack(bus_ack), .bus_rd_data(bus_rd_data), .bus_err(bus_err)
  );

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_tmo_dut (
    .clk(clk), .rst(rst), .mem_op(t_op), .mem_addr(t_addr),
    .mem_wr_data(32'h0), .mem_stall(1'b0), .mem_flush(1'b0),
    .mem_busy(t_busy), .rd_data(t_rd_data), .rd_valid(t_valid), .mem_err(t_err),
    .bus_req(t_req), .bus_rw(t_rw), .bus_addr(t_bus_addr), .bus_wr_data(t_bus_wr_data),
    .bus_size(t_size), .bus_ack(1'b0), .bus_rd_data(32'h0), .bus_err(1'b0)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Monitor: every new completion pops one expected result; also counts bus transactions
  always @(negedge clk) begin
    if (!rst && rd_valid && !valid_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: completion data 0x%08h with empty queue", rd_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk32("sb_rd_data", rd_data, e.data);
        chk1("sb_mem_err", mem_err, e.err);
      end
    end
    valid_prev = rd_valid;
    if (bus_req && !req_prev) req_rises++;
    req_prev = bus_req;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mem_op = 4'h0; mem_addr = 32'h0; mem_wr_data = 32'h0;
    mem_stall = 1'b0; mem_flush = 1'b0; bus_ack = 1'b0; bus_rd_data = 32'h0;
    bus_err = 1'b0; t_op = 4'h0; t_addr = 32'h0;
    nxt; nxt;
    smp;
    chk1("rst_busy", mem_busy, 1'b0);
    chk1("rst_req", bus_req, 1'b0);
    chk1("rst_valid", rd_valid, 1'b0);
    chk1("rst_err", mem_err, 1'b0);
    chk32("rst_rd_data", rd_data, 32'h0);
    chk32("rst_bus_addr", bus_addr, 32'h0);
    chk32("rst_size", 32'(bus_size), 32'h0);
    nxt; rst = 1'b0;
    smp;

    // Load 0x100, ack in cycle 3
    nxt; mem_op = 4'b1010; mem_addr = 32'h100; exp_q.push_back('{32'hDEADBEEF, 1'b0});
    smp; chk1("ld_busy_c0", mem_busy, 1'b1); chk1("ld_req_c0", bus_req, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      nxt;
      if (c == 3) begin bus_ack = 1'b1; bus_rd_data = 32'hDEADBEEF; end
      smp;
      chk1("ld_busy", mem_busy, 1'b1);
      chk1("ld_req", bus_req, 1'b1);
      chk1("ld_rw", bus_rw, 1'b0);
      chk32("ld_addr", bus_addr, 32'h100);
      chk32("ld_size", 32'(bus_size), 32'h2);
    end
    nxt; bus_ack = 1'b0; bus_rd_data = 32'h0;
    smp; chk1("ld_busy_c4", mem_busy, 1'b0); chk1("ld_valid_c4", rd_valid, 1'b1);
    chk1("ld_req_c4", bus_req, 1'b0);
    nxt; mem_op = 4'h0;
    smp; chk1("ld_valid_c5", rd_valid, 1'b0);

    // Store 0x55AA to 0x200, ack in cycle 1 (read data must be ignored)
    nxt; mem_op = 4'b0101; mem_addr = 32'h200; mem_wr_data = 32'h55AA;
    exp_q.push_back('{32'h0, 1'b0});
    smp; chk1("st_busy_c0", mem_busy, 1'b1);
    nxt; bus_ack = 1'b1; bus_rd_data = 32'h12345678;
    smp; chk1("st_req_c1", bus_req, 1'b1); chk1("st_rw", bus_rw, 1'b1);
    chk32("st_wdata", bus_wr_data, 32'h55AA); chk32("st_addr", bus_addr, 32'h200);
    nxt; bus_ack = 1'b0; bus_rd_data = 32'h0;
    smp; chk1("st_busy_c2", mem_busy, 1'b0); chk1("st_valid_c2", rd_valid, 1'b1);
    nxt; mem_op = 4'h0;
    smp; chk1("st_valid_c3", rd_valid, 1'b0);

    // Load with the pipeline stalled after completion: result held, no re-issue
    nxt; rises_before = req_rises; mem_op = 4'b1000; mem_addr = 32'h300;
    exp_q.push_back('{32'hCAFEF00D, 1'b0});
    nxt; mem_stall = 1'b1; bus_ack = 1'b1; bus_rd_data = 32'hCAFEF00D;
    for (int c = 2; c <= 6; c++) begin
      nxt; bus_ack = 1'b0; bus_rd_data = 32'h0;
      smp;
      chk1("stl_valid", rd_valid, 1'b1);
      chk32("stl_rd_data", rd_data, 32'hCAFEF00D);
      chk1("stl_req", bus_req, 1'b0);
      chk1("stl_busy", mem_busy, 1'b0);
    end
    nxt; mem_stall = 1'b0;
    smp; chk1("stl_valid_c7", rd_valid, 1'b1);
    nxt; mem_op = 4'h0;
    smp; chk1("stl_valid_c8", rd_valid, 1'b0);
    nxt; chk32("stl_one_txn", 32'(req_rises - rises_before), 32'd1);

    // Flush in cycle 2, ack (with error) in cycle 6: drained and discarded
    mem_op = 4'b1000; mem_addr = 32'h400;
    smp; chk1("fl_busy_c0", mem_busy, 1'b1);
    nxt;
    smp; chk1("fl_req_c1", bus_req, 1'b1);
    nxt; mem_flush = 1'b1;
    smp; chk1("fl_busy_c2", mem_busy, 1'b1);
    for (int c = 3; c <= 6; c++) begin
      nxt;
      if (c == 3) begin mem_flush = 1'b0; mem_op = 4'h0; end
      if (c == 6) begin bus_ack = 1'b1; bus_err = 1'b1; bus_rd_data = 32'hBAD0BAD0; end
      smp;
      chk1("fl_busy", mem_busy, 1'b1);
      chk1("fl_req", bus_req, 1'b1);
      chk1("fl_valid", rd_valid, 1'b0);
      chk1("fl_err", mem_err, 1'b0);
    end
    nxt; bus_ack = 1'b0; bus_err = 1'b0; bus_rd_data = 32'h0;
    smp; chk1("fl_busy_c7", mem_busy, 1'b0); chk1("fl_req_c7", bus_req, 1'b0);
    chk1("fl_valid_c7", rd_valid, 1'b0); chk1("fl_err_c7", mem_err, 1'b0);

    // Load terminated by bus_err
    nxt; mem_op = 4'b1001; mem_addr = 32'h500; exp_q.push_back('{32'h11111111, 1'b1});
    nxt;
    nxt; bus_ack = 1'b1; bus_err = 1'b1; bus_rd_data = 32'h11111111;
    nxt; bus_ack = 1'b0; bus_err = 1'b0; bus_rd_data = 32'h0;
    smp; chk1("be_valid", rd_valid, 1'b1); chk1("be_err", mem_err, 1'b1);
    nxt; mem_op = 4'h0;
    smp; chk1("be_err_clr", mem_err, 1'b0);

    // Store completes, then flush while stalled in DONE clears the result
    nxt; mem_op = 4'b0110; mem_addr = 32'h600; mem_wr_data = 32'hA5A5;
    exp_q.push_back('{32'h0, 1'b0});
    nxt; bus_ack = 1'b1; mem_stall = 1'b1;
    smp; chk1("fd_rw", bus_rw, 1'b1);
    nxt; bus_ack = 1'b0; mem_flush = 1'b1;
    smp; chk1("fd_valid_c2", rd_valid, 1'b1);
    nxt; mem_flush = 1'b0; mem_stall = 1'b0; mem_op = 4'h0;
    smp; chk1("fd_valid_c3", rd_valid, 1'b0); chk1("fd_busy_c3", mem_busy, 1'b0);

    // Flush in IDLE blocks the access; stray ack in IDLE is ignored
    nxt; mem_op = 4'b1000; mem_addr = 32'h700; mem_flush = 1'b1; bus_ack = 1'b1;
    smp; chk1("fi_busy", mem_busy, 1'b0);
    nxt; mem_op = 4'h0; mem_flush = 1'b0; bus_ack = 1'b0;
    smp; chk1("fi_req", bus_req, 1'b0); chk1("fi_valid", rd_valid, 1'b0);

    // Reset in the middle of ACCESS
    nxt; mem_op = 4'b1000; mem_addr = 32'h800;
    nxt;
    smp; chk1("rm_req_c1", bus_req, 1'b1);
    nxt; rst = 1'b1;
    nxt; rst = 1'b0; mem_op = 4'h0;
    smp; chk1("rm_req", bus_req, 1'b0); chk1("rm_busy", mem_busy, 1'b0);
    chk1("rm_valid", rd_valid, 1'b0); chk1("rm_err", mem_err, 1'b0);
    chk32("rm_bus_addr", bus_addr, 32'h0); chk32("rm_rd_data", rd_data, 32'h0);

    // Timeout after 4 cycles with no ack on the TIMEOUT=4 instance
    nxt; t_op = 4'b1000; t_addr = 32'h900;
    smp; chk1("to_busy_c0", t_busy, 1'b1); chk1("to_req_c0", t_req, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      nxt;
      smp; chk1("to_req", t_req, 1'b1); chk1("to_busy", t_busy, 1'b1);
    end
    nxt;
    smp; chk1("to_req_c5", t_req, 1'b0); chk1("to_busy_c5", t_busy, 1'b0);
    chk1("to_valid_c5", t_valid, 1'b1); chk1("to_err_c5", t_err, 1'b1);
    chk32("to_rd_data_c5", t_rd_data, 32'h0);
    nxt; t_op = 4'h0;
    smp; chk1("to_valid_c6", t_valid, 1'b0); chk1("to_err_c6", t_err, 1'b0);

    nxt;
    chk32("total_txns", 32'(req_rises), 32'd7);
    chk32("sb_pending", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage access sequencer; the producer side of the pipeline stall protocol.
- Turns the MEM-stage load/store into a req/ack transaction on the data bus.
- Drives mem_busy into the pipeline control unit, which answers with mem_stall/mem_flush.
- Holds the completed result stable while the pipeline is stalled for other reasons, e.g. if_busy.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, data width
TIMEOUT, 255, max cycles waiting for bus_ack before error completion (8-bit counter; must be >=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
mem_op  in  4  MEM-stage memory op; 1XXX = load, 01XX = store, others = no access
mem_addr  in  ADDR_W  access address
mem_wr_data  in  DATA_W  store data
mem_stall  in  1  MEM-stage stall from pipeline control
mem_flush  in  1  MEM-stage flush from pipeline control
mem_busy  out  1  access in progress; pipeline must stall
rd_data  out  DATA_W  load result
rd_valid  out  1  rd_data/completion valid for the op at MEM
mem_err  out  1  access ended on bus_err or timeout
bus_req  out  1  bus request, held until bus_ack
bus_rw  out  1  1 = write, 0 = read
bus_addr  out  ADDR_W  registered address
bus_wr_data  out  DATA_W  registered store data
bus_size  out  2  mem_op[1:0] passed through, registered
bus_ack  in  1  bus completion, single-cycle pulse
bus_rd_data  in  DATA_W  read data, valid with bus_ack
bus_err  in  1  bus error, valid with bus_ack

Behaviour:
- access = mem_op[3] | (mem_op[3:2]==2'b01).
- States:
  - IDLE
  - ACCESS
  - DONE
  - DRAIN (flushed transaction still outstanding on the bus)
- Reset: state IDLE; all outputs 0; timeout count 0.
  - Reset mid-transaction: bus_req drops at that edge; an in-flight transaction is abandoned and the bus tolerates the orphaned ack.
- mem_busy (combinational):
  - 1 in IDLE when access && !mem_flush.
  - 1 in ACCESS and in DRAIN.
  - 0 in DONE.
- IDLE:
  - access && !mem_flush: latch addr, data, rw and size into the bus_* registers; go ACCESS.
  - mem_flush: no access is started.
- ACCESS:
  - bus_req=1 and bus_* stable.
  - Timeout count increments each cycle without bus_ack.
  - On bus_ack: capture bus_rd_data into rd_data (loads only; stores leave rd_data at 0); mem_err=bus_err; drop bus_req at the same edge; go DONE.
  - Count reaches TIMEOUT without bus_ack: drop bus_req, mem_err=1, go DONE.
  - mem_flush in ACCESS: go DRAIN (bus_req still held).
- DRAIN:
  - bus_req=1 until bus_ack or timeout, then go IDLE.
  - rd_valid and mem_err stay 0; the result is discarded.
- DONE:
  - rd_valid=1; rd_data/mem_err held stable.
  - mem_stall=1: stay in DONE and never re-issue the same op.
  - mem_stall=0: the pipeline advances at this edge; go IDLE and clear rd_valid/mem_err.
  - mem_flush=1: go IDLE and clear outputs, regardless of stall.
- Latency: op presented in cycle 0 → bus_req high in cycle 1 → earliest ack in cycle 1 → DONE (busy=0, rd_valid=1) in cycle 2.
- bus_ack outside ACCESS/DRAIN is ignored.
- Timeout counter clears on every entry to ACCESS; it saturates and does not wrap.
- Exactly one bus transaction per MEM-stage op, including under arbitrary mem_stall patterns.

Decomposition:
- Shared package/header: state encoding (MAC_IDLE, MAC_ACCESS, MAC_DONE, MAC_DRAIN), mem_op load/store decode masks, bus_rw encodings (BUS_READ/BUS_WRITE).
- One natural sub-module: mac_timeout_cnt (clear / enable / saturate, terminal-count output).

Test Plan:
- Load addr 0x100, bus_ack in cycle 3 with data 0xDEADBEEF → mem_busy=1 in cycles 0–3; bus_req=1 in cycles 1–3 with bus_rw=0; cycle 4 rd_valid=1, rd_data=0xDEADBEEF.
- Store 0x55AA to 0x200 with bus_ack in cycle 1 → bus_rw=1, bus_wr_data=0x55AA; mem_busy falls in cycle 2; rd_data=0.
- Ack with mem_stall held 5 more cycles → stays DONE, rd_data stable, bus_req never re-asserts (exactly one transaction).
- mem_flush in cycle 2 of an access, ack in cycle 6 → mem_busy=1 through cycle 6; rd_valid and mem_err stay 0; IDLE in cycle 7.
- TIMEOUT=4 with no ack → bus_req drops after 4 cycles; DONE with mem_err=1; bus_err on ack → mem_err=1.
- rst asserted mid-ACCESS → next cycle bus_req=0, mem_busy=0 (no op), all outputs 0.
